// File: rtl/queue_pkg.sv
// Shared types and constants for the queue read-side controller.
package queue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/queue_reader_if.sv
// Queue read port plus valid/ready output stream, as seen by the reader (master).
interface queue_reader_if
  import queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  logic              q_en_o;
  logic              q_rw_o;
  logic [DATA_W-1:0] q_data_i;
  logic              q_empty_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;

  modport master (
    output q_en_o,
    output q_rw_o,
    input  q_data_i,
    input  q_empty_i,
    output m_valid_o,
    input  m_ready_i,
    output m_data_o
  );

  modport slave (
    input  q_en_o,
    input  q_rw_o,
    output q_data_i,
    output q_empty_i,
    input  m_valid_o,
    output m_ready_i,
    input  m_data_o
  );

endinterface

// File: rtl/queue_reader_out_buf2.sv
// Two-entry in-order FIFO; entry 0 is always the head so head data is a plain register.
module out_buf2
  import queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] e0_q, e1_q;
  logic [1:0]        cnt_q;
  logic              do_push, do_pop;

  assign do_pop  = pop & (cnt_q != 2'd0);
  assign do_push = push & ((cnt_q != 2'd2) | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= wdata;
          else               e1_q <= wdata;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; new word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            e0_q <= wdata;
          end else begin
            e0_q <= e1_q;
            e1_q <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign head  = e0_q;

endmodule

// File: rtl/queue_reader.sv
// Drains the single-port queue into a 2-entry buffer and streams it out with backpressure.
module queue_reader
  import queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  queue_reader_if.master   bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] words_o
);

  state_e            state_q;
  logic              busy_q;
  logic [CNT_W-1:0]  words_q;
  logic [1:0]        count;
  logic [DATA_W-1:0] head;
  logic              push, pop, m_valid;

  // Reset gating keeps a stale RUN state from strobing the queue in the reset cycle.
  assign push    = (state_q == StRun) & ~bus.q_empty_i & (count < 2'd2) & ~Rst_i;
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & bus.m_ready_i;

  out_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (Clk_i),
    .rst   (Rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (bus.q_data_i),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      words_q <= '0;
    end else begin
      if (pop) words_q <= words_q + CNT_W'(1);
      unique case (state_q)
        StIdle: begin
          if (start_i & ~stop_i) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (stop_i) state_q <= StDrain;
        end
        StDrain: begin
          if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_en_o    = push;
  assign bus.q_rw_o    = RW_READ;
  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = head;
  assign busy_o        = busy_q;
  assign words_o       = words_q;

endmodule
